fetch_trace_monitor: RTL and testbench
======================================

Name: fetch_trace_monitor

Overview:
- Sits downstream of the chip top-level and consumes its fetch observation outputs: fetch_inst/inst_valid and fetch_data/data_valid.
- Captures each valid instruction or data word into a tagged trace FIFO and keeps per-stream event counters.
- Maintains a running rotate-XOR signature of all captured words.
- Exposes the trace through a valid/ready read port, so benches and on-chip debug can compare a run against a golden signature.

Parameters:
- WORD_WIDTH, 32, width of fetch_inst, fetch_data and each trace word.
- DEPTH, 8, trace FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 16, width of inst_cnt and data_cnt.
- SIG_SEED, 32'h0, signature value loaded at reset and at capture start.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  capture enable; a rising edge arms capture, low ends it.
- fetch_inst  in  WORD_WIDTH  instruction word from chip.
- inst_valid  in  1  fetch_inst qualifier.
- fetch_data  in  WORD_WIDTH  data word from chip.
- data_valid  in  1  fetch_data qualifier.
- out_ready  in  1  consumer accepts the head entry.
- out_valid  out  1  FIFO non-empty.
- out_tag  out  1  head entry source: 0 = instruction, 1 = data.
- out_word  out  WORD_WIDTH  head entry word.
- inst_cnt  out  CNT_WIDTH  accepted instruction events since capture start.
- data_cnt  out  CNT_WIDTH  accepted data events since capture start.
- signature  out  WORD_WIDTH  running signature.
- overflow  out  1  sticky; at least one event was dropped.
- busy  out  1  high while in CAPTURE.

Behaviour:
- Reset (async, active-high):
  - State IDLE, FIFO empty (pointers and count 0).
  - out_valid=0, out_tag=0, out_word=0, inst_cnt=0, data_cnt=0, signature=SIG_SEED, overflow=0, busy=0.
  - start_q (previous start) = 0.
- FSM, two states:
  - IDLE→CAPTURE when start=1 and start_q=0. On that edge: inst_cnt, data_cnt and overflow clear; signature loads SIG_SEED. FIFO contents are retained.
  - CAPTURE→IDLE on any edge where start=0.
  - busy = (state==CAPTURE), registered.
- Capture qualification:
  - An event is captured only on an edge where state==CAPTURE and start=1.
  - Valids in IDLE, including in the arming cycle itself, are ignored.
- Writes (up to two per cycle):
  - free = DEPTH − count, using count at the start of the cycle; a same-cycle pop is not credited.
  - inst_valid only: one entry {0,fetch_inst} if free≥1, else dropped.
  - data_valid only: one entry {1,fetch_data} if free≥1, else dropped.
  - Both valid:
    - free≥2: inst entry at wptr, data entry at wptr+1 (order inst then data).
    - free==1: inst accepted, data dropped.
    - free==0: both dropped.
  - Any drop sets overflow; it stays set until reset or the next capture start.
- Counters:
  - Increment only for accepted events.
  - Saturate at all-ones, no wrap.
- Signature:
  - For each accepted word w, in the same order as the writes: sig = rotl1(sig) ^ w.
  - Both accepted in one cycle: sig' = rotl1(rotl1(sig)^inst) ^ data.
  - Dropped words do not affect sig.
- Read port:
  - out_valid = (count≠0); out_tag/out_word = head entry, driven from registers.
  - When out_valid=0, out_tag=0 and out_word=0.
  - Pop on edge with out_valid&&out_ready.
  - Push and pop in the same cycle are both applied: count' = count + pushes − pop.
- Latency:
  - Event accepted on edge N → visible at the head (if FIFO was empty) and counted/signed after edge N.
  - Pointers wrap modulo DEPTH.
- Reset mid-capture: all state returns to reset values immediately; in-flight FIFO data is lost.
- Reading continues normally in IDLE; the FIFO drains without new writes.

Test Plan:
- Reset, start rise, then inst_valid for 3 cycles with 0x00000013, 0x00100093, 0x00200113 → three entries tag 0 in order; inst_cnt=3, data_cnt=0, overflow=0.
- SIG_SEED=0, one cycle with both valid, inst=0xAAAA0000, data=0x12345678 → entries inst then data; signature=0x47605679; inst_cnt=1, data_cnt=1.
- out_ready=0, 9 single inst events into DEPTH=8 → 8 stored, 9th dropped; overflow=1, inst_cnt=8; releasing out_ready drains 8 entries in order, then out_valid=0.
- FIFO at 7 entries, both valid → inst stored, data dropped; count=8, overflow=1, data_cnt unchanged; signature includes only the inst word.
- Valids asserted in IDLE and in the start-rise cycle → no entries, counters 0. Drop start mid-stream → busy=0 after the next edge; later valids ignored.
- Capture 4 entries, assert rst for one cycle mid-stream → out_valid=0, counters 0, signature=SIG_SEED and busy=0 immediately (asynchronous); capture resumes only on a new start rise.

Source files
------------

// File: rtl/fetch_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_trace_monitor
//  Description : Captures qualified instruction/data fetch words into a tagged
//                trace FIFO, counts accepted events per stream and keeps a
//                running rotate-XOR signature. The trace is read out through
//                a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_trace_monitor #(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    DEPTH      = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [WORD_WIDTH-1:0] SIG_SEED   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] fetch_inst,
    input  logic                  inst_valid,
    input  logic [WORD_WIDTH-1:0] fetch_data,
    input  logic                  data_valid,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_tag,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic [CNT_WIDTH-1:0]  inst_cnt,
    output logic [CNT_WIDTH-1:0]  data_cnt,
    output logic [WORD_WIDTH-1:0] signature,
    output logic                  overflow,
    output logic                  busy
);

    localparam int                  c_ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W:0]   c_DEPTH    = (c_ADDR_W+1)'(DEPTH);
    localparam logic [c_ADDR_W:0]   c_DEPTH_M1 = (c_ADDR_W+1)'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_start_q;
    logic [c_ADDR_W-1:0]     r_wptr;
    logic [c_ADDR_W-1:0]     r_rptr;
    logic [c_ADDR_W:0]       r_count;
    logic [WORD_WIDTH:0]     r_mem [DEPTH];
    logic [CNT_WIDTH-1:0]    r_inst_cnt;
    logic [CNT_WIDTH-1:0]    r_data_cnt;
    logic [WORD_WIDTH-1:0]   r_sig;
    logic                    r_overflow;
    logic                    r_busy;

    logic                    w_cap;
    logic                    w_free_ge1;
    logic                    w_free_ge2;
    logic                    w_inst_acc;
    logic                    w_data_acc;
    logic                    w_drop;
    logic                    w_pop;
    logic [c_ADDR_W-1:0]     w_data_addr;
    logic [WORD_WIDTH-1:0]   w_sig_a;
    logic [WORD_WIDTH-1:0]   w_sig_b;
    logic [WORD_WIDTH:0]     w_head;

    function automatic logic [WORD_WIDTH-1:0] rotl1(input logic [WORD_WIDTH-1:0] v);
        return {v[WORD_WIDTH-2:0], v[WORD_WIDTH-1]};
    endfunction

    // Acceptance decisions use the occupancy at the start of the cycle; a pop
    // in the same cycle does not make room for a push.
    always_comb begin
        w_cap       = (r_state == ST_CAPTURE) && start;
        w_free_ge1  = (r_count != c_DEPTH);
        w_free_ge2  = (r_count < c_DEPTH_M1);
        w_inst_acc  = w_cap && inst_valid && w_free_ge1;
        w_data_acc  = w_cap && data_valid && (w_inst_acc ? w_free_ge2 : w_free_ge1);
        w_drop      = w_cap && ((inst_valid && !w_inst_acc) || (data_valid && !w_data_acc));
        w_pop       = out_valid && out_ready;
        w_data_addr = w_inst_acc ? (r_wptr + c_ADDR_W'(1)) : r_wptr;
        w_sig_a     = w_inst_acc ? (rotl1(r_sig) ^ fetch_inst) : r_sig;
        w_sig_b     = w_data_acc ? (rotl1(w_sig_a) ^ fetch_data) : w_sig_a;
    end

    // Trace storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_inst_acc) begin
            r_mem[r_wptr] <= {1'b0, fetch_inst};
        end
        if (w_data_acc) begin
            r_mem[w_data_addr] <= {1'b1, fetch_data};
        end
    end

    // Control FSM, FIFO bookkeeping, counters, signature and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_start_q  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inst_cnt <= '0;
            r_data_cnt <= '0;
            r_sig      <= SIG_SEED;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_start_q <= start;
            r_wptr    <= r_wptr + c_ADDR_W'(w_inst_acc) + c_ADDR_W'(w_data_acc);
            r_rptr    <= r_rptr + c_ADDR_W'(w_pop);
            r_count   <= r_count + (c_ADDR_W+1)'(w_inst_acc)
                                 + (c_ADDR_W+1)'(w_data_acc)
                                 - (c_ADDR_W+1)'(w_pop);
            case (r_state)
                ST_IDLE: begin
                    if (start && !r_start_q) begin
                        r_state    <= ST_CAPTURE;
                        r_busy     <= 1'b1;
                        r_inst_cnt <= '0;
                        r_data_cnt <= '0;
                        r_overflow <= 1'b0;
                        r_sig      <= SIG_SEED;
                    end
                end
                ST_CAPTURE: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_inst_acc && (r_inst_cnt != c_CNT_MAX)) begin
                            r_inst_cnt <= r_inst_cnt + 1'b1;
                        end
                        if (w_data_acc && (r_data_cnt != c_CNT_MAX)) begin
                            r_data_cnt <= r_data_cnt + 1'b1;
                        end
                        if (w_drop) begin
                            r_overflow <= 1'b1;
                        end
                        r_sig <= w_sig_b;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign out_valid = (r_count != '0);
    assign out_tag   = out_valid & w_head[WORD_WIDTH];
    assign out_word  = out_valid ? w_head[WORD_WIDTH-1:0] : '0;
    assign inst_cnt  = r_inst_cnt;
    assign data_cnt  = r_data_cnt;
    assign signature = r_sig;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fetch_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_trace_monitor
//  Description : Directed self-checking bench for fetch_trace_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_trace_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] fetch_inst;
    logic        inst_valid;
    logic [31:0] fetch_data;
    logic        data_valid;
    logic        out_ready;
    logic        out_valid;
    logic        out_tag;
    logic [31:0] out_word;
    logic [15:0] inst_cnt;
    logic [15:0] data_cnt;
    logic [31:0] signature;
    logic        overflow;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_trace_monitor #(
        .WORD_WIDTH (32),
        .DEPTH      (8),
        .CNT_WIDTH  (16),
        .SIG_SEED   (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fetch_inst (fetch_inst),
        .inst_valid (inst_valid),
        .fetch_data (fetch_data),
        .data_valid (data_valid),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_tag    (out_tag),
        .out_word   (out_word),
        .inst_cnt   (inst_cnt),
        .data_cnt   (data_cnt),
        .signature  (signature),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the head entry, then pop it.
    task automatic pop_chk(input string tag, input logic exp_tag, input logic [31:0] exp_word);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".tag"},   {31'b0, out_tag},   {31'b0, exp_tag});
        chk({tag, ".word"},  out_word,           exp_word);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fetch_inst = '0; inst_valid = 1'b0;
        fetch_data = '0; data_valid = 1'b0; out_ready = 1'b0;
        #12;
        // Reset state
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.out_tag",   {31'b0, out_tag},   32'd0);
        chk("rst.out_word",  out_word,           32'd0);
        chk("rst.inst_cnt",  {16'b0, inst_cnt},  32'd0);
        chk("rst.data_cnt",  {16'b0, data_cnt},  32'd0);
        chk("rst.signature", signature,          32'd0);
        chk("rst.overflow",  {31'b0, overflow},  32'd0);
        chk("rst.busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        step();

        // Three instruction captures; valid in the arming cycle is ignored
        start = 1'b1; inst_valid = 1'b1; fetch_inst = 32'hDEAD_BEEF;
        step();
        chk("t1.arm_busy",  {31'b0, busy},      32'd1);
        chk("t1.arm_empty", {31'b0, out_valid}, 32'd0);
        chk("t1.arm_cnt",   {16'b0, inst_cnt},  32'd0);
        fetch_inst = 32'h0000_0013; step();
        fetch_inst = 32'h0010_0093; step();
        fetch_inst = 32'h0020_0113; step();
        inst_valid = 1'b0;
        chk("t1.inst_cnt",  {16'b0, inst_cnt},  32'd3);
        chk("t1.data_cnt",  {16'b0, data_cnt},  32'd0);
        chk("t1.overflow",  {31'b0, overflow},  32'd0);
        chk("t1.signature", signature,          32'h0000_0079);
        pop_chk("t1.e0", 1'b0, 32'h0000_0013);
        pop_chk("t1.e1", 1'b0, 32'h0010_0093);
        pop_chk("t1.e2", 1'b0, 32'h0020_0113);
        chk("t1.empty", {31'b0, out_valid}, 32'd0);
        chk("t1.word0", out_word,           32'd0);

        // Both valid in one cycle: inst then data
        start = 1'b0; step();
        chk("t2.busy_off", {31'b0, busy}, 32'd0);
        start = 1'b1; step();
        inst_valid = 1'b1; fetch_inst = 32'hAAAA_0000;
        data_valid = 1'b1; fetch_data = 32'h1234_5678;
        step();
        inst_valid = 1'b0; data_valid = 1'b0;
        chk("t2.signature", signature,         32'h4760_5679);
        chk("t2.inst_cnt",  {16'b0, inst_cnt}, 32'd1);
        chk("t2.data_cnt",  {16'b0, data_cnt}, 32'd1);
        pop_chk("t2.e0", 1'b0, 32'hAAAA_0000);
        pop_chk("t2.e1", 1'b1, 32'h1234_5678);
        chk("t2.empty", {31'b0, out_valid}, 32'd0);

        // Nine single inst events into an 8-deep FIFO with no reads
        start = 1'b0; step();
        start = 1'b1; step();
        for (int i = 0; i < 9; i++) begin
            inst_valid = 1'b1; fetch_inst = 32'h100 + 32'(i);
            step();
        end
        inst_valid = 1'b0;
        chk("t3.inst_cnt", {16'b0, inst_cnt}, 32'd8);
        chk("t3.overflow", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop_chk("t3.drain", 1'b0, 32'h100 + 32'(i));
        end
        chk("t3.empty", {31'b0, out_valid}, 32'd0);

        // Seven entries, then both valid: inst kept, data dropped
        start = 1'b0; step();
        start = 1'b1; step();
        chk("t4.ovf_clr", {31'b0, overflow}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            inst_valid = 1'b1; fetch_inst = 32'(i);
            step();
        end
        inst_valid = 1'b1; fetch_inst = 32'h0000_00F0;
        data_valid = 1'b1; fetch_data = 32'h0000_00D0;
        step();
        inst_valid = 1'b0; data_valid = 1'b0;
        chk("t4.inst_cnt",  {16'b0, inst_cnt}, 32'd8);
        chk("t4.data_cnt",  {16'b0, data_cnt}, 32'd0);
        chk("t4.overflow",  {31'b0, overflow}, 32'd1);
        chk("t4.signature", signature,         32'h0000_00EE);
        for (int i = 1; i <= 7; i++) begin
            pop_chk("t4.drain", 1'b0, 32'(i));
        end
        pop_chk("t4.last", 1'b0, 32'h0000_00F0);
        chk("t4.empty", {31'b0, out_valid}, 32'd0);

        // Valids in IDLE and in the arming cycle are ignored; stop ends capture
        start = 1'b0; step();
        inst_valid = 1'b1; data_valid = 1'b1;
        step(); step();
        chk("t5.idle_empty", {31'b0, out_valid}, 32'd0);
        start = 1'b1; step();
        chk("t5.arm_empty", {31'b0, out_valid}, 32'd0);
        chk("t5.arm_icnt",  {16'b0, inst_cnt},  32'd0);
        chk("t5.arm_dcnt",  {16'b0, data_cnt},  32'd0);
        data_valid = 1'b0; fetch_inst = 32'h0000_0055;
        step();
        chk("t5.one_cnt", {16'b0, inst_cnt}, 32'd1);
        start = 1'b0;
        step();
        chk("t5.stop_busy", {31'b0, busy}, 32'd0);
        step();
        inst_valid = 1'b0;
        chk("t5.stop_cnt", {16'b0, inst_cnt}, 32'd1);
        pop_chk("t5.e0", 1'b0, 32'h0000_0055);
        chk("t5.empty", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-capture
        start = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            inst_valid = 1'b1; fetch_inst = 32'hA0 + 32'(i);
            step();
        end
        fetch_inst = 32'hA4;
        chk("t6.pre_cnt", {16'b0, inst_cnt}, 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("t6.rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t6.rst_icnt",  {16'b0, inst_cnt},  32'd0);
        chk("t6.rst_sig",   signature,          32'd0);
        chk("t6.rst_busy",  {31'b0, busy},      32'd0);
        #1 rst = 1'b0;
        start = 1'b0;
        step();
        chk("t6.no_cap",  {31'b0, out_valid}, 32'd0);
        chk("t6.no_busy", {31'b0, busy},      32'd0);
        start = 1'b1; step();
        chk("t6.rearm_busy",  {31'b0, busy},      32'd1);
        chk("t6.rearm_empty", {31'b0, out_valid}, 32'd0);
        fetch_inst = 32'h0000_00B0; step();
        inst_valid = 1'b0;
        chk("t6.cnt",  {16'b0, inst_cnt}, 32'd1);
        chk("t6.sig",  signature,         32'h0000_00B0);
        pop_chk("t6.e0", 1'b0, 32'h0000_00B0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
